perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- Parametrised hardware performance-counter bank for the RV32I pipeline; generalises the fixed cycle/instruction/stall/branch/mispredict counters exported by top.
- One free-running cycle counter plus NUM_EVENTS event counters, each fed by a single-cycle pulse from the datapath: retire, stall, branch, mispredict, icache stall, ...
- Adds global enable, synchronous clear, snapshot bank, sticky overflow flags, optional saturation, periodic windowed sampling and a registered indexed read port for the testbench or future CSR logic.

Parameters:
- NUM_EVENTS, 8, number of event counters; counters are indexed 1..NUM_EVENTS.
- COUNTER_WIDTH, 32, width of every counter and of rd_data.
- WINDOW_CYCLES, 0, length of the auto-sampling window in enabled cycles; 0 disables windowing.
- SATURATE, 0, overflow mode: 0 = wrap to 0, 1 = hold at all-ones.
- ADDR_W, $clog2(NUM_EVENTS+1), width of rd_addr.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global count enable; when low, no counter advances
- event_in  in  NUM_EVENTS  event pulses; bit i-1 increments counter i by 1
- clear  in  1  synchronous clear of live counters and overflow flags
- snapshot_req  in  1  copies live values into the snapshot bank
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  counter index; 0 = cycle counter
- rd_data  out  COUNTER_WIDTH  snapshot value at the requested index
- rd_valid  out  1  rd_data valid
- overflow  out  NUM_EVENTS+1  sticky per-counter overflow flags; bit 0 = cycle counter
- window_done  out  1  one-cycle pulse at the end of each window

Behaviour:
- Reset: all live counters, snapshots, overflow, rd_data, rd_valid, window_done and the window counter go to 0.
- Per cycle, the increment for counter 0 is enable. For counter i, the increment is enable & event_in[i-1].
- The next value of each counter is live + increment, with overflow handled as follows:
  - Wrap mode: all-ones + 1 becomes 0, and the overflow bit is set.
  - Saturate mode: all-ones + 1 holds at all-ones, and the overflow bit is set.
  - Overflow bits are sticky until clear or reset.
- Snapshot: on snapshot_req, snapshot[i] <= next value, including the current cycle's increment. The live counters keep running.
- clear: live counters and overflow go to 0 next cycle, and any increment in the same cycle is dropped. Snapshots are not affected.
- clear and snapshot_req in the same cycle: the snapshot captures the next value, then the live counters become 0.
- Window, active when WINDOW_CYCLES > 0:
  - The window counter advances only on enabled cycles.
  - On the enabled cycle where the window counter equals WINDOW_CYCLES-1:
    - perform an implicit snapshot;
    - clear the live counters (overflow flags kept);
    - reset the window counter to 0;
    - assert window_done on the next cycle for one cycle.
  - Windows are disjoint and back-to-back.
  - clear also resets the window counter.
- Read port: rd_en at cycle N gives rd_valid=1 and rd_data=snapshot[rd_addr] at cycle N+1.
  - If rd_addr > NUM_EVENTS, rd_data = 0 and rd_valid = 1.
  - If rd_en is low, rd_valid = 0 and rd_data holds its last value.
  - A read and a snapshot in the same cycle return the old snapshot value.
- Reset mid-window or mid-read: everything returns to the reset values; any pending rd_valid is dropped.
- enable low: counters and the window counter freeze. Snapshot, clear and read still operate.

Decomposition:
- perf_pkg holds:
  - index constants: IDX_CYCLE=0, IDX_RETIRE=1, IDX_STALL=2, IDX_BRANCH=3, IDX_MISPRED=4, IDX_ICSTALL=5;
  - overflow mode constants: MODE_WRAP, MODE_SAT.
- Sub-module perf_counter_cell, instantiated NUM_EVENTS+1 times via generate:
  - inputs: inc, clear, snapshot;
  - outputs: live, snap, ovf;
  - contains the saturate/wrap logic.
- perf_counter_bank holds the window FSM (IDLE-free counter plus done pulse) and the read mux/register.

Test Plan:
- Basic counting: reset, enable=1 for 10 cycles, event_in[0] pulsed 4 times, snapshot_req on cycle 10, read addr 0 and 1 -> rd_data 10 and 4, each with rd_valid one cycle after rd_en.
- Overflow (COUNTER_WIDTH=8, SATURATE=0): 257 pulses on event 0 -> counter 1 = 1 and overflow[1]=1. The same stimulus with SATURATE=1 -> counter 1 = 255 and overflow[1]=1. clear -> overflow=0.
- Simultaneous events:
  - clear, snapshot_req and event_in[1] in the same cycle with live counter 2 = 7 -> snapshot 8, live 0.
  - A read on the next cycle -> 8.
- Window (WINDOW_CYCLES=16): events on every cycle -> window_done pulses at cycles 17, 33, ...; the snapshot of counter 0 is 16 after each window. Dropping enable for 5 cycles delays the next pulse by 5.
- Out-of-range and freeze:
  - rd_addr = NUM_EVENTS+1 -> rd_data 0, rd_valid 1.
  - enable=0 with events asserted -> no counter change.
  - Reset asserted mid-window -> all outputs 0 and no window_done pulse.

Source files
------------

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared index and overflow-mode constants for the perf counter bank
package perf_pkg;

    localparam int IDX_CYCLE   = 0;
    localparam int IDX_RETIRE  = 1;
    localparam int IDX_STALL   = 2;
    localparam int IDX_BRANCH  = 3;
    localparam int IDX_MISPRED = 4;
    localparam int IDX_ICSTALL = 5;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/perf_counter_cell.sv
// rtl/perf_counter_cell.sv - one live counter with snapshot register and sticky overflow flag
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int SATURATE      = MODE_WRAP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     clear,
    input  logic                     clear_ovf,
    input  logic                     snapshot,
    output logic [COUNTER_WIDTH-1:0] live,
    output logic [COUNTER_WIDTH-1:0] snap,
    output logic                     ovf
);

    logic                     all_ones;
    logic                     ovf_evt;
    logic [COUNTER_WIDTH-1:0] next_val;

    assign all_ones = &live;
    assign ovf_evt  = inc & all_ones;

    always_comb begin
        next_val = live;
        if (inc) begin
            if (all_ones)
                next_val = (SATURATE == MODE_SAT) ? live : '0;
            else
                next_val = live + COUNTER_WIDTH'(1);
        end
    end

    // Snapshot sees this cycle's increment even when clear drops it from the live value.
    always_ff @(posedge clk) begin
        if (reset) begin
            live <= '0;
            snap <= '0;
            ovf  <= 1'b0;
        end else begin
            if (snapshot)
                snap <= next_val;
            live <= clear ? '0 : next_val;
            ovf  <= clear_ovf ? 1'b0 : (ovf | ovf_evt);
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - cycle plus event counter bank with snapshots, windowing and registered read port
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS    = 8,
    parameter int COUNTER_WIDTH = 32,
    parameter int WINDOW_CYCLES = 0,
    parameter int SATURATE      = 0,
    parameter int ADDR_W        = $clog2(NUM_EVENTS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_EVENTS-1:0]    event_in,
    input  logic                     clear,
    input  logic                     snapshot_req,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [COUNTER_WIDTH-1:0] rd_data,
    output logic                     rd_valid,
    output logic [NUM_EVENTS:0]      overflow,
    output logic                     window_done
);

    logic [NUM_EVENTS:0][COUNTER_WIDTH-1:0] live_bank;
    logic [NUM_EVENTS:0][COUNTER_WIDTH-1:0] snap_bank;
    logic [NUM_EVENTS:0]                    inc_vec;
    logic                                   win_hit;
    logic [COUNTER_WIDTH-1:0]               rd_mux;
    logic                                   unused_live;

    assign unused_live = ^live_bank;

    generate
        if (WINDOW_CYCLES > 0) begin : g_window
            localparam int WC_W = $clog2(WINDOW_CYCLES + 1);
            logic [WC_W-1:0] win_cnt_q;
            logic [WC_W-1:0] win_cnt_d;

            always_ff @(posedge clk) begin
                if (reset)
                    win_cnt_q <= '0;
                else
                    win_cnt_q <= win_cnt_d;
            end

            always_comb begin
                win_cnt_d = win_cnt_q;
                if (clear || win_hit)
                    win_cnt_d = '0;
                else if (enable)
                    win_cnt_d = win_cnt_q + WC_W'(1);
            end

            assign win_hit = enable && (win_cnt_q == WC_W'(WINDOW_CYCLES - 1));
        end else begin : g_no_window
            assign win_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            window_done <= 1'b0;
        else
            window_done <= win_hit;
    end

    generate
        for (genvar i = 0; i <= NUM_EVENTS; i++) begin : g_cell
            if (i == IDX_CYCLE) begin : g_cyc
                assign inc_vec[i] = enable;
            end else begin : g_evt
                assign inc_vec[i] = enable & event_in[i-1];
            end

            // A window boundary restarts the counts but keeps the sticky overflow history.
            perf_counter_cell #(
                .COUNTER_WIDTH (COUNTER_WIDTH),
                .SATURATE      (SATURATE)
            ) u_cell (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc_vec[i]),
                .clear     (clear | win_hit),
                .clear_ovf (clear),
                .snapshot  (snapshot_req | win_hit),
                .live      (live_bank[i]),
                .snap      (snap_bank[i]),
                .ovf       (overflow[i])
            );
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i <= NUM_EVENTS; i++) begin
            if (rd_addr == ADDR_W'(i))
                rd_mux = snap_bank[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed self-checking bench over four parameterisations of perf_counter_bank
module tb_perf_counter_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] event_in = '0;
    logic       clear = 1'b0;
    logic       snapshot_req = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;

    logic [31:0] m_rd_data;
    logic        m_rd_valid;
    logic [8:0]  m_ovf;
    logic        m_wd;
    logic [7:0]  w_rd_data;
    logic        w_rd_valid;
    logic [8:0]  w_ovf;
    logic        w_wd;
    logic [7:0]  s_rd_data;
    logic        s_rd_valid;
    logic [8:0]  s_ovf;
    logic        s_wd;
    logic [31:0] n_rd_data;
    logic        n_rd_valid;
    logic [8:0]  n_ovf;
    logic        n_wd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    perf_counter_bank u_main (
        .clk(clk), .reset(reset), .enable(enable), .event_in(event_in), .clear(clear),
        .snapshot_req(snapshot_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(m_rd_data), .rd_valid(m_rd_valid), .overflow(m_ovf), .window_done(m_wd)
    );

    perf_counter_bank #(.COUNTER_WIDTH(8), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .event_in(event_in), .clear(clear),
        .snapshot_req(snapshot_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(w_rd_data), .rd_valid(w_rd_valid), .overflow(w_ovf), .window_done(w_wd)
    );

    perf_counter_bank #(.COUNTER_WIDTH(8), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .event_in(event_in), .clear(clear),
        .snapshot_req(snapshot_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .overflow(s_ovf), .window_done(s_wd)
    );

    perf_counter_bank #(.WINDOW_CYCLES(16)) u_win (
        .clk(clk), .reset(reset), .enable(enable), .event_in(event_in), .clear(clear),
        .snapshot_req(snapshot_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(n_rd_data), .rd_valid(n_rd_valid), .overflow(n_ovf), .window_done(n_wd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        enable = 1'b0; event_in = '0; clear = 1'b0; snapshot_req = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_m_valid", 64'(m_rd_valid), 64'd0);
        chk("rst_m_data", 64'(m_rd_data), 64'd0);
        chk("rst_m_ovf", 64'(m_ovf), 64'd0);
        chk("rst_n_wd", 64'(n_wd), 64'd0);
        reset = 1'b0;

        // basic counting: 10 enabled cycles, 4 pulses on event 0, snapshot on the 10th
        for (int i = 0; i < 10; i++) begin
            enable = 1'b1;
            event_in = (i % 3 == 0) ? 8'h01 : 8'h00;
            snapshot_req = (i == 9);
            tick();
        end
        idle_inputs();
        rd_en = 1'b1; rd_addr = 4'd0; tick();
        chk("basic_valid0", 64'(m_rd_valid), 64'd1);
        chk("basic_cycle", 64'(m_rd_data), 64'd10);
        rd_addr = 4'd1; tick();
        chk("basic_valid1", 64'(m_rd_valid), 64'd1);
        chk("basic_retire", 64'(m_rd_data), 64'd4);
        rd_en = 1'b0; tick();
        chk("rd_idle_valid", 64'(m_rd_valid), 64'd0);
        chk("rd_idle_hold", 64'(m_rd_data), 64'd4);

        // out-of-range read
        rd_en = 1'b1; rd_addr = 4'd9; tick();
        chk("oor_valid", 64'(m_rd_valid), 64'd1);
        chk("oor_data", 64'(m_rd_data), 64'd0);
        rd_en = 1'b0;

        // freeze: events without enable change nothing
        event_in = 8'hFF;
        tick(); tick();
        snapshot_req = 1'b1; tick();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 4'd0; tick();
        chk("freeze_cycle", 64'(m_rd_data), 64'd10);
        rd_addr = 4'd1; tick();
        chk("freeze_retire", 64'(m_rd_data), 64'd4);
        rd_en = 1'b0;

        // clear + snapshot + event in one cycle with live counter 2 at 7
        clear = 1'b1; tick();
        clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            enable = 1'b1; event_in = 8'h02; tick();
        end
        clear = 1'b1; snapshot_req = 1'b1; tick();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 4'd2; tick();
        chk("simul_snap2", 64'(m_rd_data), 64'd8);
        rd_addr = 4'd0; tick();
        chk("simul_snap0", 64'(m_rd_data), 64'd8);
        rd_en = 1'b0; snapshot_req = 1'b1; tick();
        snapshot_req = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd2; tick();
        chk("simul_live2_zero", 64'(m_rd_data), 64'd0);
        rd_en = 1'b0;

        // overflow with 8-bit counters, wrap and saturate
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 257; i++) begin
            enable = 1'b1; event_in = 8'h01; snapshot_req = (i == 256); tick();
        end
        idle_inputs();
        chk("ovf_wrap_flags", 64'(w_ovf), 64'h003);
        chk("ovf_sat_flags", 64'(s_ovf), 64'h003);
        chk("ovf_main_flags", 64'(m_ovf), 64'h000);
        rd_en = 1'b1; rd_addr = 4'd1; tick();
        chk("ovf_wrap_cnt1", 64'(w_rd_data), 64'd1);
        chk("ovf_sat_cnt1", 64'(s_rd_data), 64'd255);
        chk("ovf_main_cnt1", 64'(m_rd_data), 64'd257);
        rd_en = 1'b0; clear = 1'b1; tick();
        clear = 1'b0;
        chk("clr_wrap_flags", 64'(w_ovf), 64'h000);
        chk("clr_sat_flags", 64'(s_ovf), 64'h000);
        rd_en = 1'b1; tick();
        chk("clr_keeps_snap", 64'(w_rd_data), 64'd1);
        rd_en = 1'b0;

        // windowing: 16-cycle windows, events every cycle
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            enable = 1'b1; event_in = 8'hFF; tick();
            chk($sformatf("win_done_k%0d", k), 64'(n_wd), 64'((k % 16) == 0));
        end
        idle_inputs();
        rd_en = 1'b1; rd_addr = 4'd0; tick();
        chk("win_snap_cycle", 64'(n_rd_data), 64'd16);
        chk("win_done_after", 64'(n_wd), 64'd0);
        rd_addr = 4'd3; tick();
        chk("win_snap_evt3", 64'(n_rd_data), 64'd16);
        rd_en = 1'b0;
        tick(); tick(); tick();
        for (int k = 1; k <= 16; k++) begin
            enable = 1'b1; event_in = 8'hFF; tick();
            chk($sformatf("win_delay_k%0d", k), 64'(n_wd), 64'(k == 16));
        end

        // reset mid-window with a pending read
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b1; rd_en = 1'b1; rd_addr = 4'd0; tick();
        chk("midrst_valid", 64'(n_rd_valid), 64'd0);
        chk("midrst_data", 64'(n_rd_data), 64'd0);
        chk("midrst_wd", 64'(n_wd), 64'd0);
        chk("midrst_ovf", 64'(n_ovf), 64'd0);
        reset = 1'b0; rd_en = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            enable = 1'b1; tick();
            chk($sformatf("midrst_win_k%0d", k), 64'(n_wd), 64'(k == 16));
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
